// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: shared types for the instruction cache
package diaosi_types_pkg;
  typedef enum logic {IC_IDLE, IC_FETCH} icache_state_t;
  localparam int IC_DEF_SETS = 16;
  localparam int IC_DEF_WORD_W = 32;
  localparam int IC_DEF_IDX_W = $clog2(IC_DEF_SETS);
  localparam int IC_DEF_TAG_W = IC_DEF_WORD_W - IC_DEF_IDX_W - 2;
  typedef struct packed {
    logic valid;
    logic [IC_DEF_TAG_W-1:0] tag;
    logic [IC_DEF_WORD_W-1:0] data;
  } icache_frame_t;
endpackage

// File: rtl/icache_frames.sv
// icache_frames: frame array with async read, sync fill and sync clear-all
module icache_frames #(
  parameter int SETS = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 26,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [WORD_W-1:0] rdata
);
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [WORD_W-1:0] data [SETS];
  // clear beats a fill landing on the same edge
  always_ff @(posedge CLK) begin
    if (clr) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end
  assign rvalid = valid[ridx];
  assign rtag = tags[ridx];
  assign rdata = data[ridx];
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with single-word fills
module icache_dm
  import diaosi_types_pkg::*;
#(
  parameter int SETS = IC_DEF_SETS,
  parameter int WORD_W = IC_DEF_WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dp_iren,
  input  logic [WORD_W-1:0] dp_iaddr,
  output logic              dp_ihit,
  output logic [WORD_W-1:0] dp_iload,
  input  logic              ic_flush,
  output logic              mem_iren,
  output logic [WORD_W-1:0] mem_iaddr,
  input  logic              mem_iwait,
  input  logic [WORD_W-1:0] mem_iload,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;
  icache_state_t state;
  logic [WORD_W-1:0] miss_addr;
  logic rvalid, hit, fill;
  logic [TAG_W-1:0] rtag;
  logic [WORD_W-1:0] rdata;
  icache_frames #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .WORD_W(WORD_W)) u_frames (
    .CLK(CLK),
    .clr(RST | ic_flush),
    .we(fill),
    .widx(miss_addr[IDX_W+1:2]),
    .wtag(miss_addr[WORD_W-1:IDX_W+2]),
    .wdata(mem_iload),
    .ridx(dp_iaddr[IDX_W+1:2]),
    .rvalid(rvalid),
    .rtag(rtag),
    .rdata(rdata)
  );
  assign hit = (state == IC_IDLE) && dp_iren && rvalid && (rtag == dp_iaddr[WORD_W-1:IDX_W+2]);
  assign fill = (state == IC_FETCH) && !mem_iwait;
  assign dp_ihit = hit;
  assign dp_iload = hit ? rdata : '0;
  assign mem_iren = state == IC_FETCH;
  assign mem_iaddr = miss_addr;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IC_IDLE;
      miss_addr <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (hit) hit_count <= hit_count + 32'd1;
      if (state == IC_IDLE && dp_iren && !hit) begin
        miss_addr <= {dp_iaddr[WORD_W-1:2], 2'b00};
        miss_count <= miss_count + 32'd1;
        state <= IC_FETCH;
      end else if (fill) begin
        state <= IC_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed scenario tests for icache_dm
module tb_icache_dm;
  logic CLK = 0, RST = 0, dp_iren = 0, ic_flush = 0, mem_iwait = 1;
  logic [31:0] dp_iaddr = 0, mem_iload = 0;
  logic dp_ihit, mem_iren;
  logic [31:0] dp_iload, mem_iaddr, hit_count, miss_count;
  int n_checks = 0, n_fail = 0;

  icache_dm dut (
    .CLK(CLK), .RST(RST), .dp_iren(dp_iren), .dp_iaddr(dp_iaddr),
    .dp_ihit(dp_ihit), .dp_iload(dp_iload), .ic_flush(ic_flush),
    .mem_iren(mem_iren), .mem_iaddr(mem_iaddr), .mem_iwait(mem_iwait),
    .mem_iload(mem_iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // drives a miss on addr, stalls for waits cycles, then returns data
  task automatic fill(input logic [31:0] addr, input logic [31:0] d, input int waits);
    dp_iren = 1; dp_iaddr = addr; mem_iwait = 1;
    tick();
    repeat (waits) tick();
    mem_iwait = 0; mem_iload = d;
    tick();
    mem_iwait = 1; mem_iload = 0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1; dp_iren = 0;
    tick();
    RST = 0; #1;
    n_checks++; if (dp_ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit got %b want 0", dp_ihit); end
    n_checks++; if (dp_iload !== 32'h0) begin n_fail++; $display("FAIL reset_iload got %h want 0", dp_iload); end
    n_checks++; if (mem_iren !== 1'b0) begin n_fail++; $display("FAIL reset_miren got %b want 0", mem_iren); end
    n_checks++; if (mem_iaddr !== 32'h0) begin n_fail++; $display("FAIL reset_miaddr got %h want 0", mem_iaddr); end
    n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count, miss_count); end
  endtask

  task automatic test_cold_miss();
    dp_iren = 1; dp_iaddr = 32'h40; mem_iwait = 1; #1;
    n_checks++; if (dp_ihit !== 1'b0 || mem_iren !== 1'b0) begin n_fail++; $display("FAIL cold_c0 got ihit=%b miren=%b want 0/0", dp_ihit, mem_iren); end
    tick();
    n_checks++; if (mem_iren !== 1'b1 || mem_iaddr !== 32'h40) begin n_fail++; $display("FAIL cold_c1 got miren=%b miaddr=%h want 1/40", mem_iren, mem_iaddr); end
    n_checks++; if (dp_ihit !== 1'b0 || dp_iload !== 32'h0) begin n_fail++; $display("FAIL cold_fetch_out got ihit=%b iload=%h want 0/0", dp_ihit, dp_iload); end
    tick(); tick(); tick();
    n_checks++; if (mem_iren !== 1'b1 || mem_iaddr !== 32'h40) begin n_fail++; $display("FAIL cold_c4 got miren=%b miaddr=%h want 1/40", mem_iren, mem_iaddr); end
    mem_iwait = 0; mem_iload = 32'h2402_0001;
    tick();
    mem_iwait = 1; mem_iload = 0; #1;
    n_checks++; if (dp_ihit !== 1'b1 || dp_iload !== 32'h2402_0001) begin n_fail++; $display("FAIL cold_c5 got ihit=%b iload=%h want 1/24020001", dp_ihit, dp_iload); end
    n_checks++; if (mem_iren !== 1'b0) begin n_fail++; $display("FAIL cold_c5_miren got %b want 0", mem_iren); end
    n_checks++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL cold_misses got %0d want 1", miss_count); end
  endtask

  task automatic test_conflict();
    dp_iaddr = 32'h80; #1;
    n_checks++; if (dp_ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_80_miss got %b want 0", dp_ihit); end
    fill(32'h80, 32'hAAAA_0080, 0);
    n_checks++; if (dp_ihit !== 1'b1 || dp_iload !== 32'hAAAA_0080) begin n_fail++; $display("FAIL conflict_80_hit got %b/%h want 1/aaaa0080", dp_ihit, dp_iload); end
    dp_iaddr = 32'h40; #1;
    n_checks++; if (dp_ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_40_evicted got %b want 0", dp_ihit); end
    fill(32'h40, 32'h1111_0040, 1);
    n_checks++; if (dp_ihit !== 1'b1 || dp_iload !== 32'h1111_0040) begin n_fail++; $display("FAIL conflict_40_refill got %b/%h want 1/11110040", dp_ihit, dp_iload); end
    n_checks++; if (miss_count !== 32'd3) begin n_fail++; $display("FAIL conflict_misses got %0d want 3", miss_count); end
  endtask

  task automatic test_addr_change();
    dp_iaddr = 32'h100; #1;
    tick();
    dp_iaddr = 32'h104; #1;
    n_checks++; if (mem_iaddr !== 32'h100) begin n_fail++; $display("FAIL chg_f1 got %h want 100", mem_iaddr); end
    tick();
    n_checks++; if (mem_iaddr !== 32'h100 || mem_iren !== 1'b1) begin n_fail++; $display("FAIL chg_f2 got %h/%b want 100/1", mem_iaddr, mem_iren); end
    mem_iwait = 0; mem_iload = 32'hB000_0100;
    tick();
    mem_iwait = 1; mem_iload = 0; #1;
    n_checks++; if (dp_ihit !== 1'b0 || mem_iren !== 1'b0) begin n_fail++; $display("FAIL chg_104_miss got ihit=%b miren=%b want 0/0", dp_ihit, mem_iren); end
    tick();
    dp_iaddr = 32'h100; #1;
    n_checks++; if (mem_iaddr !== 32'h104 || mem_iren !== 1'b1) begin n_fail++; $display("FAIL chg_104_fetch got %h/%b want 104/1", mem_iaddr, mem_iren); end
    n_checks++; if (dp_ihit !== 1'b0) begin n_fail++; $display("FAIL chg_no_hit_in_fetch got %b want 0", dp_ihit); end
    mem_iwait = 0; mem_iload = 32'hB000_0104;
    tick();
    mem_iwait = 1; mem_iload = 0; #1;
    n_checks++; if (dp_ihit !== 1'b1 || dp_iload !== 32'hB000_0100) begin n_fail++; $display("FAIL chg_100_hit got %b/%h want 1/b0000100", dp_ihit, dp_iload); end
    dp_iaddr = 32'h104; #1;
    n_checks++; if (dp_ihit !== 1'b1 || dp_iload !== 32'hB000_0104) begin n_fail++; $display("FAIL chg_104_hit got %b/%h want 1/b0000104", dp_ihit, dp_iload); end
    n_checks++; if (miss_count !== 32'd5) begin n_fail++; $display("FAIL chg_misses got %0d want 5", miss_count); end
  endtask

  task automatic test_flush();
    fill(32'h0, 32'hC000_0000, 0);
    n_checks++; if (dp_ihit !== 1'b1 || dp_iload !== 32'hC000_0000) begin n_fail++; $display("FAIL flush_pre_hit got %b/%h want 1/c0000000", dp_ihit, dp_iload); end
    dp_iren = 0; ic_flush = 1;
    tick();
    ic_flush = 0; dp_iren = 1; #1;
    n_checks++; if (dp_ihit !== 1'b0) begin n_fail++; $display("FAIL flush_miss got %b want 0", dp_ihit); end
    fill(32'h0, 32'hC000_0001, 0);
    n_checks++; if (dp_ihit !== 1'b1 || dp_iload !== 32'hC000_0001) begin n_fail++; $display("FAIL flush_refill got %b/%h want 1/c0000001", dp_ihit, dp_iload); end
    dp_iaddr = 32'h8; #1;
    tick();
    mem_iwait = 0; mem_iload = 32'hD000_0008; ic_flush = 1;
    tick();
    mem_iwait = 1; mem_iload = 0; ic_flush = 0; #1;
    n_checks++; if (dp_ihit !== 1'b0) begin n_fail++; $display("FAIL flush_same_edge got %b want 0", dp_ihit); end
    fill(32'h8, 32'hD000_0009, 0);
    n_checks++; if (dp_ihit !== 1'b1 || dp_iload !== 32'hD000_0009) begin n_fail++; $display("FAIL flush_later_fill got %b/%h want 1/d0000009", dp_ihit, dp_iload); end
    n_checks++; if (miss_count !== 32'd9) begin n_fail++; $display("FAIL flush_misses got %0d want 9", miss_count); end
  endtask

  task automatic test_reset_mid_fill();
    fill(32'h200, 32'hE000_0200, 0);
    dp_iaddr = 32'h204; #1;
    tick();
    tick();
    RST = 1;
    tick();
    RST = 0; dp_iaddr = 32'h200; #1;
    n_checks++; if (mem_iren !== 1'b0) begin n_fail++; $display("FAIL rstmid_miren got %b want 0", mem_iren); end
    n_checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_counts got %0d/%0d want 0/0", hit_count, miss_count); end
    n_checks++; if (dp_ihit !== 1'b0) begin n_fail++; $display("FAIL rstmid_prior_miss got %b want 0", dp_ihit); end
    tick();
    n_checks++; if (mem_iren !== 1'b1 || mem_iaddr !== 32'h200 || miss_count !== 32'd1) begin n_fail++; $display("FAIL rstmid_refetch got %b/%h/%0d want 1/200/1", mem_iren, mem_iaddr, miss_count); end
    mem_iwait = 0; mem_iload = 32'hE000_0201;
    tick();
    mem_iwait = 1; mem_iload = 0; #1;
    n_checks++; if (dp_ihit !== 1'b1 || dp_iload !== 32'hE000_0201) begin n_fail++; $display("FAIL rstmid_refill got %b/%h want 1/e0000201", dp_ihit, dp_iload); end
  endtask

  task automatic test_hit_count();
    RST = 1; dp_iren = 0;
    tick();
    RST = 0;
    fill(32'h300, 32'hF000_0300, 0);
    n_checks++; if (hit_count !== 32'd0 || miss_count !== 32'd1) begin n_fail++; $display("FAIL hits_start got %0d/%0d want 0/1", hit_count, miss_count); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (mem_iren !== 1'b0 || dp_ihit !== 1'b1) begin n_fail++; $display("FAIL hits_cycle%0d got miren=%b ihit=%b want 0/1", i, mem_iren, dp_ihit); end
      tick();
    end
    dp_iren = 0; #1;
    n_checks++; if (hit_count !== 32'd10) begin n_fail++; $display("FAIL hits_total got %0d want 10", hit_count); end
    tick();
    n_checks++; if (hit_count !== 32'd10 || dp_ihit !== 1'b0) begin n_fail++; $display("FAIL hits_idle got %0d/%b want 10/0", hit_count, dp_ihit); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_addr_change();
    test_flush();
    test_reset_mid_fill();
    test_hit_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache placed between each core's fetch stage and the bus arbiter's instruction port (`iREN`/`iaddr`/`iwait`/`iload`). One instance per CPU. Hits return in the same cycle. On a miss the block issues a single-word fill to the arbiter, writes the frame, and then returns the word as a hit. It also keeps free-running hit and miss counters for performance runs.

## Interface
Parameters:
- `SETS`, 16: number of frames. Power of two, 2..256. `IDX_W = $clog2(SETS)`.
- `WORD_W`, 32: instruction and address width.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `dp_iren`  in  1  fetch request from the datapath.
- `dp_iaddr`  in  32  fetch byte address, word aligned. Bits [1:0] are ignored.
- `dp_ihit`  out  1  `dp_iload` is valid this cycle.
- `dp_iload`  out  32  instruction word. Zero when `dp_ihit` = 0.
- `ic_flush`  in  1  one-cycle pulse that invalidates all frames.
- `mem_iren`  out  1  fill request to the arbiter.
- `mem_iaddr`  out  32  fill word address.
- `mem_iwait`  in  1  arbiter stall. 0 means `mem_iload` is valid this cycle.
- `mem_iload`  in  32  fill data.
- `hit_count`  out  32  count of hit cycles.
- `miss_count`  out  32  count of misses.

## Operation
Address split:
- tag = `dp_iaddr[31:IDX_W+2]`
- index = `dp_iaddr[IDX_W+1:2]`
- offset = `dp_iaddr[1:0]`, ignored.

Storage per frame: valid bit, tag, data word.

State machine, `icache_state_t`:
- `IC_IDLE`:
  - hit = `dp_iren` & valid[idx] & (tag[idx] == addr tag).
  - On a hit: `dp_ihit`=1 and `dp_iload`=data[idx] combinationally.
  - On `dp_iren` & !hit: latch `dp_iaddr & ~3` into `miss_addr`, increment `miss_count`, go to `IC_FETCH`.
- `IC_FETCH`:
  - Drive `mem_iren`=1 and `mem_iaddr`=`miss_addr`. `dp_ihit`=0.
  - When `mem_iwait`=0: write data, tag, and valid=1 into frame `miss_addr` index, then go to `IC_IDLE`.

Counters:
- `hit_count` increments every cycle `dp_ihit`=1.
- Both counters wrap modulo 2^32.

Boundary rules:
- **Datapath changes or drops the request during `IC_FETCH`:** the fill still completes to `miss_addr`. Lookup resumes in `IC_IDLE` with the current `dp_iaddr`.
- **`ic_flush`:** clears every valid bit on its edge, in any state.
  - If a fill completes on the same edge, flush wins and the filled frame is left invalid.
  - A fill completing on a later edge sets valid normally.
  - `ic_flush` never aborts `IC_FETCH`, because the arbiter cannot accept a withdrawn request.
- **`ic_flush` coincident with a miss in `IC_IDLE`:** the miss is taken normally.
- **Index conflict:** a fill replaces the frame unconditionally.
- **`RST` during `IC_FETCH`:** return to `IC_IDLE` and clear all valid bits. `mem_iren` is 0 from the next cycle.

Reset values (synchronous, on the `RST` edge):
- state = `IC_IDLE`
- all valid bits = 0
- `miss_addr` = 0
- both counters = 0

Resulting outputs after reset: `dp_ihit`=0, `dp_iload`=0, `mem_iren`=0, `mem_iaddr`=0.

## Timing
- Hit: zero-cycle latency, combinational from `dp_iaddr` to `dp_ihit`/`dp_iload`.
- Miss:
  - Detected in cycle 0.
  - `mem_iren`=1 from cycle 1.
  - If `mem_iwait` first drops in cycle k, the frame is written at the end of cycle k and `dp_ihit`=1 in cycle k+1.
  - Minimum miss penalty is 2 cycles (k = 1).
- `mem_iren`/`mem_iaddr` are registered-state outputs and stay stable for the whole of `IC_FETCH`.
- `mem_iload` is sampled only in the cycle where `mem_iwait`=0.
- `dp_ihit` is never asserted in `IC_FETCH`, even if `dp_iaddr` matches another valid frame.

## Structure
- `diaosi_types_pkg` gains:
  - `icache_state_t` = {`IC_IDLE`, `IC_FETCH`}.
  - `icache_frame_t` packed struct {valid, tag, data}, built for the default `SETS`.
- Sub-module `icache_frames` holds the frame array.
  - One combinational read port, indexed by the lookup index.
  - One synchronous write port: fill.
  - Synchronous clear-all: flush or reset.
  - Clear has priority over write.
- FSM, `miss_addr` register, counters, and output muxing stay in `icache_dm`.

## Test plan
- **Cold miss then hit.** After reset, `dp_iren`=1, `dp_iaddr`=0x0000_0040; arbiter holds `mem_iwait`=1 for 3 cycles, then returns 0x2402_0001.
  - `mem_iren` rises in cycle 1 with `mem_iaddr`=0x40.
  - `dp_ihit`=1 with `dp_iload`=0x2402_0001 in cycle 5.
  - `miss_count`=1.
- **Conflict eviction.** Fill 0x40, then fetch 0x80 (same index for `SETS`=16) and fill it, then fetch 0x40 again.
  - Three misses, `miss_count`=3.
  - The final fetch of 0x40 returns the re-filled word.
- **Address change mid-fill.** Miss on 0x100, and `dp_iaddr` changes to 0x104 during `IC_FETCH`.
  - `mem_iaddr` stays 0x100 throughout.
  - 0x104 then misses separately.
- **Flush.**
  - Fill 0x0, pulse `ic_flush`, fetch 0x0: a miss is required.
  - Flush on the same edge as fill completion: the next fetch of that address misses again.
- **Reset mid-fill.** Assert `RST` in the second `IC_FETCH` cycle.
  - Next cycle: `mem_iren`=0, counters 0, state `IC_IDLE`.
  - The prior address misses.
- **Hit counting.** Hold a hitting fetch for 10 cycles: `hit_count` increases by exactly 10 and `mem_iren` stays 0.
